// File: rtl/cc_block_multi.sv
// ============================================================================
// cc_block_multi : ChaCha keystream block generator, multi-block runs,
//                  configurable rounds and micro-ops per clock.
// Revision 1.0
// ============================================================================
`default_nettype none

module cc_block_multi #(
  parameter int ROUNDS = 20,
  parameter int UNROLL = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_cnt,
  input  logic [15:0]  i_nblk,
  input  logic         i_ready,
  output logic [511:0] o_stream,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  generate
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20) ||
        !(UNROLL == 1 || UNROLL == 3 || UNROLL == 12)) begin : g_bad_param
      $error("cc_block_multi: illegal ROUNDS/UNROLL combination");
    end
  endgenerate

  localparam logic [3:0] C_UNROLL  = 4'(UNROLL);
  localparam logic [3:0] C_LAST_OP = 4'(12 - UNROLL);
  localparam logic [4:0] C_LAST_RD = 5'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RND  = 3'd2,
    S_ADD  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [255:0]        key_q, key_d;
  logic [95:0]         non_q, non_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [15:0]         nblk_q, nblk_d;
  logic [15:0][31:0]   w_q, w_d;
  logic [3:0]          op_q, op_d;
  logic [4:0]          rnd_q, rnd_d;
  logic [511:0]        stream_q, stream_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [15:0][31:0]   w_init;
  logic [15:0][31:0]   w_stage [UNROLL+1];

  // One micro-op applied to all four independent quarter-rounds at once.
  function automatic logic [15:0][31:0] uop(input logic [15:0][31:0] s,
                                            input logic [3:0] op,
                                            input logic diag);
    logic [15:0][31:0] r;
    logic [3:0]        ia, ib, ic, id;
    r = s;
    for (int q = 0; q < 4; q++) begin
      ia = 4'(q);
      ib = {2'b01, 2'(q) + {1'b0, diag}};
      ic = {2'b10, 2'(q) + {diag, 1'b0}};
      id = {2'b11, 2'(q) + {diag, diag}};
      case (op)
        4'd0, 4'd6: r[ia] = r[ia] + r[ib];
        4'd1, 4'd7: r[id] = r[id] ^ r[ia];
        4'd2:       r[id] = {r[id][15:0], r[id][31:16]};
        4'd3, 4'd9: r[ic] = r[ic] + r[id];
        4'd4, 4'd10: r[ib] = r[ib] ^ r[ic];
        4'd5:       r[ib] = {r[ib][19:0], r[ib][31:20]};
        4'd8:       r[id] = {r[id][23:0], r[id][31:24]};
        4'd11:      r[ib] = {r[ib][24:0], r[ib][31:25]};
        default:    r = s;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    w_init[0]  = 32'h61707865;
    w_init[1]  = 32'h3320646e;
    w_init[2]  = 32'h79622d32;
    w_init[3]  = 32'h6b206574;
    for (int k = 0; k < 8; k++) begin
      w_init[4+k] = key_q[32*k +: 32];
    end
    w_init[12] = cnt_q;
    w_init[13] = non_q[31:0];
    w_init[14] = non_q[63:32];
    w_init[15] = non_q[95:64];
  end

  assign w_stage[0] = w_q;

  generate
    for (genvar u = 0; u < UNROLL; u++) begin : g_uop
      assign w_stage[u+1] = uop(w_stage[u], op_q + 4'(u), rnd_q[0]);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    non_d    = non_q;
    cnt_d    = cnt_q;
    nblk_d   = nblk_q;
    w_d      = w_q;
    op_d     = op_q;
    rnd_d    = rnd_q;
    stream_d = stream_q;
    valid_d  = valid_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          key_d   = i_key;
          non_d   = i_non;
          cnt_d   = i_cnt;
          nblk_d  = (i_nblk == 16'd0) ? 16'd1 : i_nblk;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        w_d     = w_init;
        op_d    = 4'd0;
        rnd_d   = 5'd0;
        state_d = S_RND;
      end
      S_RND: begin
        w_d = w_stage[UNROLL];
        if (op_q == C_LAST_OP) begin
          op_d  = 4'd0;
          rnd_d = rnd_q + 5'd1;
          if (rnd_q == C_LAST_RD) begin
            state_d = S_ADD;
          end
        end else begin
          op_d = op_q + C_UNROLL;
        end
      end
      S_ADD: begin
        for (int i = 0; i < 16; i++) begin
          stream_d[511-32*i -: 32] = w_q[i] + w_init[i];
        end
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          nblk_d  = nblk_q - 16'd1;
          if (nblk_q > 16'd1) begin
            // Counter wrap would repeat keystream, so the run aborts instead.
            if (cnt_q == 32'hFFFF_FFFF) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + 32'd1;
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      non_q    <= '0;
      cnt_q    <= '0;
      nblk_q   <= '0;
      w_q      <= '0;
      op_q     <= '0;
      rnd_q    <= '0;
      stream_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      non_q    <= non_d;
      cnt_q    <= cnt_d;
      nblk_q   <= nblk_d;
      w_q      <= w_d;
      op_q     <= op_d;
      rnd_q    <= rnd_d;
      stream_q <= stream_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_stream = stream_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cc_block_multi.sv
// ============================================================================
// tb_cc_block_multi : directed bench for cc_block_multi (RFC 8439 vector,
//                     multi-block, backpressure, overflow, start/reset abuse).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cc_block_multi;

  localparam int LAT1 = 242;
  localparam logic [511:0] C_RFC =
    512'he4e7f110_15593bd1_1fdd0f50_c47120a3_c7f4d1c7_0368c033_9aaa2204_4e6cd4c3_466482d2_09aa9f07_05d7c214_a2028bd9_d19c12b5_b94e16de_e883d0cb_4e3c50a2;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         start_x = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  non = '0;
  logic [31:0]  cnt = '0;
  logic [15:0]  nblk = '0;
  logic         ready = 1'b0;

  logic [511:0] o_stream, o_stream3, o_stream12;
  logic         o_valid, o_valid3, o_valid12;
  logic         o_busy, o_busy3, o_busy12;
  logic         o_done, o_done3, o_done12;
  logic         o_err, o_err3, o_err12;

  logic [255:0] rfc_key;
  logic [95:0]  rfc_non;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  cc_block_multi #(.ROUNDS(20), .UNROLL(1)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_key(key), .i_non(non),
    .i_cnt(cnt), .i_nblk(nblk), .i_ready(ready), .o_stream(o_stream),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

  cc_block_multi #(.ROUNDS(20), .UNROLL(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_x), .i_key(key), .i_non(non),
    .i_cnt(cnt), .i_nblk(nblk), .i_ready(ready), .o_stream(o_stream3),
    .o_valid(o_valid3), .o_busy(o_busy3), .o_done(o_done3), .o_err(o_err3));

  cc_block_multi #(.ROUNDS(20), .UNROLL(12)) u_dut12 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_x), .i_key(key), .i_non(non),
    .i_cnt(cnt), .i_nblk(nblk), .i_ready(ready), .o_stream(o_stream12),
    .o_valid(o_valid12), .o_busy(o_busy12), .o_done(o_done12), .o_err(o_err12));

  always @(posedge clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Reference ChaCha20 block function written from the textbook definition.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c; s[13] = n[31:0]; s[14] = n[63:32]; s[15] = n[95:64];
    x = s;
    for (int r2 = 0; r2 < 10; r2++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] nblk;
    int          stall;
    int          poke;
    int          nexp;
    logic        err;
  } vec_t;

  // Runs one i_start; checks every block against the model, latency, handshake,
  // done pulse and error flag.
  task automatic run_case(input vec_t v);
    int           lat;
    int           d0;
    logic [511:0] held;
    d0 = done_cnt;
    @(negedge clk);
    key = rfc_key; non = rfc_non; cnt = v.cnt; nblk = v.nblk;
    ready = (v.stall == 0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = ~key; non = ~non; cnt = cnt + 32'd5; nblk = nblk + 16'd7;
    chk("err_cleared_on_start", 512'(o_err), 512'(0));
    chk("busy_after_start", 512'(o_busy), 512'(1));
    for (int b = 0; b < v.nexp; b++) begin
      lat = 0;
      while (!o_valid && lat < 1000) begin
        @(negedge clk);
        lat++;
        start = (v.poke != 0 && b == 0 && lat == 100);
      end
      start = 1'b0;
      chk("block_latency", 512'(lat), 512'(LAT1));
      chk("block_data", o_stream, ref_block(rfc_key, rfc_non, v.cnt + 32'(b)));
      if (b == 0 && v.stall > 0) begin
        held = o_stream;
        for (int s = 0; s < v.stall; s++) begin
          @(negedge clk);
          chk("stall_valid_held", 512'(o_valid), 512'(1));
          chk("stall_stream_held", o_stream, held);
        end
      end
      ready = 1'b1;
      @(negedge clk);
      chk("valid_drop_on_accept", 512'(o_valid), 512'(0));
    end
    chk("done_pulse", 512'(o_done), 512'(1));
    chk("err_at_done", 512'(o_err), 512'(v.err));
    chk("busy_in_done", 512'(o_busy), 512'(1));
    @(negedge clk);
    chk("done_single_cycle", 512'(o_done), 512'(0));
    chk("busy_low_idle", 512'(o_busy), 512'(0));
    chk("valid_low_idle", 512'(o_valid), 512'(0));
    chk("done_count", 512'(done_cnt - d0), 512'(1));
    chk("err_sticky", 512'(o_err), 512'(v.err));
  endtask

  vec_t tbl [4];

  initial begin
    int           n, l1, l3, l12;
    logic [511:0] s1, s3, s12;

    for (int i = 0; i < 8; i++) begin
      rfc_key[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end
    rfc_non = {32'h0, 32'h4a000000, 32'h09000000};

    tbl[0] = '{cnt: 32'd1,          nblk: 16'd3, stall: 50, poke: 0, nexp: 3, err: 1'b0};
    tbl[1] = '{cnt: 32'hFFFF_FFFE,  nblk: 16'd4, stall: 0,  poke: 0, nexp: 2, err: 1'b1};
    tbl[2] = '{cnt: 32'd7,          nblk: 16'd0, stall: 0,  poke: 0, nexp: 1, err: 1'b0};
    tbl[3] = '{cnt: 32'd1,          nblk: 16'd1, stall: 0,  poke: 1, nexp: 1, err: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_stream", o_stream, 512'(0));
    chk("reset_flags", {o_valid, o_busy, o_done, o_err}, 512'(0));
    rstn = 1'b1;

    // RFC 8439 block vector on all three micro-op widths.
    @(negedge clk);
    key = rfc_key; non = rfc_non; cnt = 32'd1; nblk = 16'd1; ready = 1'b1;
    start = 1'b1; start_x = 1'b1;
    @(negedge clk);
    start = 1'b0; start_x = 1'b0;
    n = 0; l1 = -1; l3 = -1; l12 = -1; s1 = '0; s3 = '0; s12 = '0;
    while (l1 < 0 && n < 400) begin
      if (o_valid3 && l3 < 0) begin l3 = n; s3 = o_stream3; end
      if (o_valid12 && l12 < 0) begin l12 = n; s12 = o_stream12; end
      if (o_valid) begin l1 = n; s1 = o_stream; end
      if (l1 < 0) begin @(negedge clk); n++; end
    end
    chk("rfc_latency_u1", 512'(l1), 512'(242));
    chk("rfc_latency_u3", 512'(l3), 512'(82));
    chk("rfc_latency_u12", 512'(l12), 512'(22));
    chk("rfc_stream_u1", s1, C_RFC);
    chk("rfc_stream_u3", s3, C_RFC);
    chk("rfc_stream_u12", s12, C_RFC);
    @(negedge clk);
    chk("rfc_done_after_accept", 512'(o_done), 512'(1));
    @(negedge clk);
    chk("rfc_idle", 512'(o_busy), 512'(0));
    chk("rfc_stream_retained", o_stream, C_RFC);

    for (int i = 0; i < 4; i++) begin
      run_case(tbl[i]);
    end

    // Asynchronous reset in the middle of the rounds.
    @(negedge clk);
    key = rfc_key; non = rfc_non; cnt = 32'd1; nblk = 16'd1; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_reset_busy", 512'(o_busy), 512'(1));
    rstn = 1'b0;
    #1;
    chk("midrun_reset_stream", o_stream, 512'(0));
    chk("midrun_reset_flags", {o_valid, o_busy, o_done, o_err}, 512'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_case('{cnt: 32'd1, nblk: 16'd1, stall: 0, poke: 0, nexp: 1, err: 1'b0});
    chk("post_reset_rfc", o_stream, C_RFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
